param_updown_counter: RTL and testbench

//  Parametrised synchronous up/down counter; next generation of the 4-bit T-flip-flop down counter.

---
 rtl/param_updown_counter_pkg.sv | 10 +
 rtl/param_updown_counter_tbit.sv | 25 ++
 rtl/param_updown_counter.sv | 101 ++++++++++
 tb/tb_param_updown_counter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/param_updown_counter_pkg.sv
// Shared constants for the parametrised up/down counter family.
// Direction encodings for up_dn and the mode encodings for SATURATE.
package param_updown_counter_pkg;

  localparam logic CNT_DIR_UP    = 1'b1;
  localparam logic CNT_DIR_DN    = 1'b0;
  localparam int   CNT_MODE_WRAP = 0;
  localparam int   CNT_MODE_SAT  = 1;

endpackage

// File: rtl/param_updown_counter_tbit.sv
// T flip-flop cell with synchronous active-high reset to a per-bit initial value.
module cnt_tbit #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic q_n
);

  // State bit: reset to INIT, otherwise toggle when t is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= INIT;
    end else if (t) begin
      q <= ~q;
    end else begin
      q <= q;
    end
  end

  assign q_n = ~q;

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter built from T flip-flop cells, with
// parallel load, enable, wrap/saturate mode, terminal-count and wrap flags.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2**WIDTH,
  parameter int SATURATE = CNT_MODE_WRAP,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             wrap
);

  localparam int             WP1    = WIDTH + 1;
  localparam logic [WIDTH:0] L_MAX  = WP1'(MODULUS - 1);
  localparam logic [WIDTH:0] L_MOD  = WP1'(MODULUS);
  localparam logic [WIDTH:0] L_ONE  = WP1'(1);
  localparam logic [WIDTH:0] L_ZERO = WP1'(0);
  localparam logic [WIDTH-1:0] L_RST = WIDTH'(RST_VAL);
  localparam logic           L_SAT  = (SATURATE == CNT_MODE_SAT);

  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_wrap_next;
  logic             r_wrap;

  assign w_cnt_ext = {1'b0, count};
  assign w_at_max  = (w_cnt_ext == L_MAX);
  assign w_at_min  = (w_cnt_ext == L_ZERO);

  // Target value for the next edge; priority is load over enabled step over hold.
  always_comb begin
    w_next      = count;
    w_wrap_next = 1'b0;
    if (load) begin
      if ({1'b0, load_val} >= L_MOD) begin
        w_next = WIDTH'(L_MAX);
      end else begin
        w_next = load_val;
      end
    end else if (en) begin
      if (up_dn == CNT_DIR_UP) begin
        if (w_at_max) begin
          w_wrap_next = 1'b1;
          w_next      = L_SAT ? count : WIDTH'(L_ZERO);
        end else begin
          w_next = WIDTH'(w_cnt_ext + L_ONE);
        end
      end else begin
        if (w_at_min) begin
          w_wrap_next = 1'b1;
          w_next      = L_SAT ? count : WIDTH'(L_MAX);
        end else begin
          w_next = WIDTH'(w_cnt_ext - L_ONE);
        end
      end
    end else begin
      w_next = count;
    end
  end

  // Only the bits that differ between current and target toggle.
  assign w_t = count ^ w_next;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    cnt_tbit #(
      .INIT (L_RST[gi])
    ) u_tbit (
      .clk (clk),
      .rst (rst),
      .t   (w_t[gi]),
      .q   (count[gi]),
      .q_n (count_n[gi])
    );
  end

  // One-cycle wrap pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_next;
    end
  end

  assign wrap = r_wrap;
  assign tc   = en & ((up_dn == CNT_DIR_UP) ? w_at_max : w_at_min);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: four counter configurations, hand-computed expectations.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic [3:0] rst, en, up, load;
  logic [3:0] lv   [4];
  logic [3:0] cnt  [4];
  logic [3:0] cntn [4];
  logic [3:0] tc, wrap;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: MODULUS=10 wrap, 2: MODULUS=10 saturate, 3: RST_VAL=2
  param_updown_counter u_def (.clk(clk), .rst(rst[0]), .en(en[0]), .up_dn(up[0]), .load(load[0]),
    .load_val(lv[0]), .count(cnt[0]), .count_n(cntn[0]), .tc(tc[0]), .wrap(wrap[0]));
  param_updown_counter #(.MODULUS(10)) u_m10 (.clk(clk), .rst(rst[1]), .en(en[1]), .up_dn(up[1]),
    .load(load[1]), .load_val(lv[1]), .count(cnt[1]), .count_n(cntn[1]), .tc(tc[1]), .wrap(wrap[1]));
  param_updown_counter #(.MODULUS(10), .SATURATE(1)) u_sat (.clk(clk), .rst(rst[2]), .en(en[2]),
    .up_dn(up[2]), .load(load[2]), .load_val(lv[2]), .count(cnt[2]), .count_n(cntn[2]), .tc(tc[2]),
    .wrap(wrap[2]));
  param_updown_counter #(.RST_VAL(2)) u_rv (.clk(clk), .rst(rst[3]), .en(en[3]), .up_dn(up[3]),
    .load(load[3]), .load_val(lv[3]), .count(cnt[3]), .count_n(cntn[3]), .tc(tc[3]), .wrap(wrap[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 4'hF; en = 4'h0; up = 4'h0; load = 4'h0;
    for (int k = 0; k < 4; k++) lv[k] = 4'h0;
    tick();
    tick();
    chk("rst_cnt_def", cnt[0], 4'h0);
    chk("rst_cntn_def", cntn[0], 4'hF);
    chk("rst_wrap_def", wrap[0], 1'b0);
    chk("rst_cnt_rv", cnt[3], 4'h2);
    chk("rst_cntn_rv", cntn[3], 4'hD);

    // Defaults counting down from 0
    rst[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b0;
    #1 chk("t1_tc_at0", tc[0], 1'b1);
    tick();
    chk("t1_cnt_f", cnt[0], 4'hF);
    chk("t1_wrap_f", wrap[0], 1'b1);
    tick();
    chk("t1_cnt_e", cnt[0], 4'hE);
    chk("t1_wrap_e", wrap[0], 1'b0);
    en[0] = 1'b0;

    // MODULUS=10 counting up through the wrap
    rst[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("t2_cnt", cnt[1], 32'(i));
      chk("t2_wrap", wrap[1], 1'b0);
      chk("t2_tc", tc[1], (i == 9) ? 1'b1 : 1'b0);
    end
    tick();
    chk("t2_cnt_wrap", cnt[1], 4'h0);
    chk("t2_wrap_pulse", wrap[1], 1'b1);
    chk("t2_tc_after", tc[1], 1'b0);
    tick();
    chk("t2_wrap_clear", wrap[1], 1'b0);

    // Load clamping, then load beating enable on the same edge
    en[1] = 1'b0; load[1] = 1'b1; lv[1] = 4'd12;
    tick();
    chk("t4_clamp", cnt[1], 4'd9);
    chk("t4_clamp_wrap", wrap[1], 1'b0);
    lv[1] = 4'd3; en[1] = 1'b1;
    #1 chk("t4_tc_with_load", tc[1], 1'b1);
    tick();
    chk("t4_load_wins", cnt[1], 4'd3);
    chk("t4_load_wrap", wrap[1], 1'b0);
    load[1] = 1'b0; en[1] = 1'b0;

    // Saturating MODULUS=10: up to 9 and hold, then down to 0 and hold
    rst[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk("t3_at9", cnt[2], 4'd9);
    chk("t3_at9_wrap", wrap[2], 1'b0);
    tick();
    chk("t3_hold9", cnt[2], 4'd9);
    chk("t3_hold9_wrap", wrap[2], 1'b1);
    up[2] = 1'b0;
    tick();
    chk("t3_down8", cnt[2], 4'd8);
    chk("t3_down8_wrap", wrap[2], 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("t3_at0", cnt[2], 4'd0);
    chk("t3_tc0", tc[2], 1'b1);
    tick();
    chk("t3_hold0", cnt[2], 4'd0);
    chk("t3_hold0_wrap", wrap[2], 1'b1);
    en[2] = 1'b0;
    tick();
    chk("t3_idle_wrap", wrap[2], 1'b0);
    chk("t3_idle_cnt", cnt[2], 4'd0);

    // Reset mid-count with RST_VAL=2
    rst[3] = 1'b0; en[3] = 1'b1; up[3] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_at7", cnt[3], 4'd7);
    rst[3] = 1'b1;
    tick();
    chk("t5_rst_cnt", cnt[3], 4'd2);
    chk("t5_rst_cntn", cntn[3], 4'hD);
    chk("t5_rst_wrap", wrap[3], 1'b0);
    rst[3] = 1'b0; en[3] = 1'b0;

    // Direction toggled every cycle from 5
    load[0] = 1'b1; lv[0] = 4'd5;
    tick();
    chk("t6_load5", cnt[0], 4'd5);
    load[0] = 1'b0; en[0] = 1'b1;
    up[0] = 1'b1; tick(); chk("t6_s1", cnt[0], 4'd6);
    up[0] = 1'b0; tick(); chk("t6_s2", cnt[0], 4'd5);
    up[0] = 1'b1; tick(); chk("t6_s3", cnt[0], 4'd6);
    up[0] = 1'b0; tick(); chk("t6_s4", cnt[0], 4'd5);
    en[0] = 1'b0;
    tick();
    chk("t6_frozen", cnt[0], 4'd5);
    load[0] = 1'b1; lv[0] = 4'd0;
    tick();
    load[0] = 1'b0; up[0] = 1'b0;
    #1 chk("t6_tc_en0", tc[0], 1'b0);
    en[0] = 1'b1;
    #1 chk("t6_tc_en1", tc[0], 1'b1);
    en[0] = 1'b0;
    tick();
    chk("t6_frozen0", cnt[0], 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
